// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_pkg                                                          |
// | Shared VGA receiver constants, state encoding and count helpers. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package vga_pkg;

  localparam int unsigned c_def_h_total      = 800;
  localparam int unsigned c_def_h_sync       = 96;
  localparam int unsigned c_def_h_disp_start = 144;
  localparam int unsigned c_def_h_disp       = 640;
  localparam int unsigned c_def_v_total      = 525;
  localparam int unsigned c_def_v_sync       = 2;
  localparam int unsigned c_def_v_disp_start = 35;
  localparam int unsigned c_def_v_disp       = 480;

  localparam int unsigned c_cnt_w = 11;
  typedef logic [c_cnt_w-1:0] cnt_t;
  localparam cnt_t c_cnt_max = '1;

  localparam logic [1:0] c_st_search = 2'b00;
  localparam logic [1:0] c_st_track  = 2'b01;
  localparam logic [1:0] c_st_locked = 2'b10;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == c_cnt_max) ? v : v + cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_meas.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_edge_meas                                                   |
// | Samples one sync line, detects edges, counts period and width.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sync_edge_meas
  import vga_pkg::*;
(
  input  logic board_clk,
  input  logic reset,
  input  logic sample_en,
  input  logic sync_in,
  input  logic count_en,
  output logic fall,
  output logic rise,
  output logic seen,
  output cnt_t cnt_next,
  output cnt_t period,
  output cnt_t width
);

  logic r_sync_q;
  logic r_seen;
  cnt_t r_cnt;
  cnt_t r_width;
  cnt_t w_width_next;

  assign fall   = sample_en & r_sync_q & ~sync_in;
  assign rise   = sample_en & ~r_sync_q & sync_in;
  assign seen   = r_seen;
  assign period = sat_inc(r_cnt);
  assign width  = r_width;

  // The sample carrying the falling edge is itself the first low step.
  always_comb begin
    cnt_next     = r_cnt;
    w_width_next = r_width;
    if (fall) begin
      cnt_next     = '0;
      w_width_next = count_en ? cnt_t'(1) : '0;
    end else begin
      if (sample_en && count_en) begin
        cnt_next = sat_inc(r_cnt);
      end
      if (sample_en && count_en && !sync_in) begin
        w_width_next = sat_inc(r_width);
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_sync_q <= 1'b1;
      r_seen   <= 1'b0;
      r_cnt    <= '0;
      r_width  <= '0;
    end else begin
      if (sample_en) begin
        r_sync_q <= sync_in;
      end
      if (fall) begin
        r_seen <= 1'b1;
      end
      r_cnt   <= cnt_next;
      r_width <= w_width_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_sync_receiver                                                |
// | Recovers VGA timing from hsync/vsync, locks, flags errors.       |
// | VGA_RX_STATS_EN enables period and frame statistics outputs.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL      = c_def_h_total,
  parameter int unsigned H_SYNC       = c_def_h_sync,
  parameter int unsigned H_DISP_START = c_def_h_disp_start,
  parameter int unsigned H_DISP       = c_def_h_disp,
  parameter int unsigned V_TOTAL      = c_def_v_total,
  parameter int unsigned V_SYNC       = c_def_v_sync,
  parameter int unsigned V_DISP_START = c_def_v_disp_start,
  parameter int unsigned V_DISP       = c_def_v_disp
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  input  logic        err_clr,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_valid,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [10:0] h_period_meas,
  output logic [10:0] v_period_meas,
  output logic [7:0]  frame_cnt
);

  localparam cnt_t c_h_total      = cnt_t'(H_TOTAL);
  localparam cnt_t c_h_sync       = cnt_t'(H_SYNC);
  localparam cnt_t c_h_disp_start = cnt_t'(H_DISP_START);
  localparam cnt_t c_h_disp_end   = cnt_t'(H_DISP_START + H_DISP);
  localparam cnt_t c_v_total      = cnt_t'(V_TOTAL);
  localparam cnt_t c_v_sync       = cnt_t'(V_SYNC);
  localparam cnt_t c_v_disp_start = cnt_t'(V_DISP_START);
  localparam cnt_t c_v_disp_end   = cnt_t'(V_DISP_START + V_DISP);

  logic w_h_fall, w_h_rise, w_h_seen;
  logic w_v_fall, w_v_rise, w_v_seen;
  cnt_t w_hcnt_next, w_h_period, w_h_width;
  cnt_t w_vcnt_next, w_v_period, w_v_width;

  sync_edge_meas u_h_meas (
    .board_clk (board_clk),
    .reset     (reset),
    .sample_en (pix_ce),
    .sync_in   (vga_h_sync),
    .count_en  (1'b1),
    .fall      (w_h_fall),
    .rise      (w_h_rise),
    .seen      (w_h_seen),
    .cnt_next  (w_hcnt_next),
    .period    (w_h_period),
    .width     (w_h_width)
  );

  // Vertical counts advance in lines, i.e. on hsync assertion edges.
  sync_edge_meas u_v_meas (
    .board_clk (board_clk),
    .reset     (reset),
    .sample_en (pix_ce),
    .sync_in   (vga_v_sync),
    .count_en  (w_h_fall),
    .fall      (w_v_fall),
    .rise      (w_v_rise),
    .seen      (w_v_seen),
    .cnt_next  (w_vcnt_next),
    .period    (w_v_period),
    .width     (w_v_width)
  );

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_frame_err;
  logic       w_frame_err_next;
  logic       w_tracking;
  logic       w_h_err_det;
  logic       w_v_err_det;
  logic       w_any_err;

  assign w_h_err_det = w_h_seen & ((w_h_fall & (w_h_period != c_h_total)) |
                                   (w_h_rise & (w_h_width  != c_h_sync)));
  assign w_v_err_det = w_v_seen & ((w_v_fall & (w_v_period != c_v_total)) |
                                   (w_v_rise & (w_v_width  != c_v_sync)));
  assign w_tracking  = (r_state == c_st_track) || (r_state == c_st_locked);
  assign w_any_err   = w_tracking & (w_h_err_det | w_v_err_det);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_st_search;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  // Losing lock taints the frame in progress, so relock needs one clean frame.
  always_comb begin
    w_state_next     = r_state;
    w_frame_err_next = r_frame_err;
    case (r_state)
      c_st_search: if (w_v_fall) w_state_next = c_st_track;
      c_st_track:  if (w_v_fall && !r_frame_err && !w_any_err) w_state_next = c_st_locked;
      c_st_locked: if (w_any_err) w_state_next = c_st_track;
      default:     w_state_next = c_st_search;
    endcase
    if (w_any_err && (r_state == c_st_locked)) begin
      w_frame_err_next = 1'b1;
    end else if (w_v_fall) begin
      w_frame_err_next = 1'b0;
    end else if (w_any_err) begin
      w_frame_err_next = 1'b1;
    end
  end

  logic       w_locked_next;
  logic       w_valid_next;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_h_err_next;
  logic       w_v_err_next;

  always_comb begin
    w_locked_next = (w_state_next == c_st_locked);
    w_valid_next  = w_locked_next &&
                    (w_hcnt_next >= c_h_disp_start) && (w_hcnt_next < c_h_disp_end) &&
                    (w_vcnt_next >= c_v_disp_start) && (w_vcnt_next < c_v_disp_end);
    w_x_next = '0;
    w_y_next = '0;
    if (w_valid_next) begin
      w_x_next = 10'(w_hcnt_next - c_h_disp_start);
      w_y_next = 10'(w_vcnt_next - c_v_disp_start);
    end
    w_h_err_next = (w_tracking & w_h_err_det) | (h_err & ~err_clr);
    w_v_err_next = (w_tracking & w_v_err_det) | (v_err & ~err_clr);
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      locked   <= 1'b0;
      rx_valid <= 1'b0;
      rx_x     <= '0;
      rx_y     <= '0;
      h_err    <= 1'b0;
      v_err    <= 1'b0;
    end else begin
      locked   <= w_locked_next;
      rx_valid <= w_valid_next;
      rx_x     <= w_x_next;
      rx_y     <= w_y_next;
      h_err    <= w_h_err_next;
      v_err    <= w_v_err_next;
    end
  end

`ifdef VGA_RX_STATS_EN
  logic [10:0] r_h_period;
  logic [10:0] r_v_period;
  logic [7:0]  r_frame_cnt;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_h_period  <= '0;
      r_v_period  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_h_fall && w_h_seen) begin
        r_h_period <= w_h_period;
      end
      if (w_v_fall) begin
        r_v_period <= w_v_period;
      end
      if (w_v_fall && (r_state == c_st_locked)) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign h_period_meas = r_h_period;
  assign v_period_meas = r_v_period;
  assign frame_cnt     = r_frame_cnt;
`else
  assign h_period_meas = '0;
  assign v_period_meas = '0;
  assign frame_cnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_sync_receiver                                             |
// | Directed bench on a scaled-down VGA raster.                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_vga_sync_receiver;

  localparam int H_T   = 16;
  localparam int H_S   = 2;
  localparam int H_DS  = 4;
  localparam int H_D   = 10;
  localparam int V_T   = 10;
  localparam int V_S   = 2;
  localparam int V_DS  = 3;
  localparam int V_D   = 5;

`ifdef VGA_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        board_clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic        err_clr;
  logic [9:0]  rx_x;
  logic [9:0]  rx_y;
  logic        rx_valid;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [10:0] h_period_meas;
  logic [10:0] v_period_meas;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int ce_div = 4;
  int gh, gv, lh, lv, line_len, vs_w;

  vga_sync_receiver #(
    .H_TOTAL(H_T), .H_SYNC(H_S), .H_DISP_START(H_DS), .H_DISP(H_D),
    .V_TOTAL(V_T), .V_SYNC(V_S), .V_DISP_START(V_DS), .V_DISP(V_D)
  ) dut (
    .board_clk     (board_clk),
    .reset         (reset),
    .pix_ce        (pix_ce),
    .vga_h_sync    (vga_h_sync),
    .vga_v_sync    (vga_v_sync),
    .err_clr       (err_clr),
    .rx_x          (rx_x),
    .rx_y          (rx_y),
    .rx_valid      (rx_valid),
    .locked        (locked),
    .h_err         (h_err),
    .v_err         (v_err),
    .h_period_meas (h_period_meas),
    .v_period_meas (v_period_meas),
    .frame_cnt     (frame_cnt)
  );

  always #5 board_clk = ~board_clk;

  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pix_ce sample; returns on a falling clock edge after the update.
  task automatic tick(input logic hs, input logic vs);
    vga_h_sync = hs;
    vga_v_sync = vs;
    pix_ce     = 1'b1;
    @(negedge board_clk);
    pix_ce  = 1'b0;
    err_clr = 1'b0;
    repeat (ce_div - 1) @(negedge board_clk);
  endtask

  task automatic pixel();
    lh = gh;
    lv = gv;
    tick(gh >= H_S, gv >= vs_w);
    gh++;
    if (gh >= line_len) begin
      gh = 0;
      line_len = H_T;
      gv++;
      if (gv >= V_T) gv = 0;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    do begin
      pixel();
      n++;
    end while (!(lh == h && lv == v) && n < 4 * H_T * V_T);
  endtask

  initial begin
    reset = 1'b1; pix_ce = 1'b0; vga_h_sync = 1'b1; vga_v_sync = 1'b1; err_clr = 1'b0;
    gh = 0; gv = 0; lh = 0; lv = 0; line_len = H_T; vs_w = V_S;
    repeat (3) @(negedge board_clk);
    chk("rst_locked", locked, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_h_err", h_err, 0);
    chk("rst_v_err", v_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_h_period", h_period_meas, 0);
    chk("rst_v_period", v_period_meas, 0);
    reset = 1'b0;
    repeat (3) tick(1'b1, 1'b1);
    chk("idle_locked", locked, 0);

    // First vsync edge: tracking only
    run_to(0, 0);
    chk("vs1_locked", locked, 0);
    run_to(H_T - 1, V_T - 1);
    chk("frame1_end_locked", locked, 0);
    run_to(0, 0);
    chk("vs2_locked", locked, 1);
    chk("vs2_h_period", h_period_meas, st(H_T));
    chk("vs2_v_period", v_period_meas, st(V_T));
    chk("vs2_h_err", h_err, 0);
    chk("vs2_v_err", v_err, 0);
    chk("vs2_frame_cnt", frame_cnt, 0);

    // Display window boundaries
    run_to(H_DS - 1, V_DS);
    chk("pre_disp_valid", rx_valid, 0);
    run_to(H_DS, V_DS);
    chk("first_px_valid", rx_valid, 1);
    chk("first_px_x", rx_x, 0);
    chk("first_px_y", rx_y, 0);
    run_to(H_DS + H_D - 1, V_DS);
    chk("last_px_valid", rx_valid, 1);
    chk("last_px_x", rx_x, H_D - 1);
    run_to(H_DS + H_D, V_DS);
    chk("past_px_valid", rx_valid, 0);
    chk("past_px_x", rx_x, 0);
    run_to(H_DS + 1, V_DS + V_D - 1);
    chk("last_line_valid", rx_valid, 1);
    chk("last_line_y", rx_y, V_D - 1);
    run_to(H_DS + 1, V_DS + V_D);
    chk("past_line_valid", rx_valid, 0);
    chk("past_line_y", rx_y, 0);

    // Short line while locked
    run_to(0, 0);
    chk("frame3_cnt", frame_cnt, st(1));
    chk("frame3_locked", locked, 1);
    run_to(H_T - 1, 3);
    line_len = H_T - 1;
    run_to(H_T - 2, 4);
    chk("short_pre_locked", locked, 1);
    chk("short_pre_h_err", h_err, 0);
    pixel();
    chk("short_h_err", h_err, 1);
    chk("short_locked", locked, 0);
    chk("short_h_period", h_period_meas, st(H_T - 1));
    run_to(0, 0);
    chk("relock_vs1_locked", locked, 0);
    chk("relock_vs1_h_err", h_err, 1);
    run_to(0, 0);
    chk("relock_vs2_locked", locked, 1);
    chk("relock_vs2_h_err", h_err, 1);
    chk("relock_frame_cnt", frame_cnt, st(1));

    // Asynchronous reset mid-frame
    run_to(8, 5);
    chk("mid_valid", rx_valid, 1);
    chk("mid_x", rx_x, 8 - H_DS);
    chk("mid_y", rx_y, 5 - V_DS);
    reset = 1'b1;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_valid", rx_valid, 0);
    chk("async_rst_x", rx_x, 0);
    chk("async_rst_y", rx_y, 0);
    chk("async_rst_h_err", h_err, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    chk("async_rst_h_period", h_period_meas, 0);
    @(negedge board_clk);
    @(negedge board_clk);
    reset = 1'b0;
    run_to(0, 0);
    chk("post_rst_vs1_locked", locked, 0);

    // Three-line vsync, error raised together with err_clr
    run_to(H_T - 1, V_T - 1);
    vs_w = 3;
    run_to(0, 0);
    chk("post_rst_vs2_locked", locked, 1);
    chk("post_rst_frame_cnt", frame_cnt, 0);
    run_to(H_T - 1, 2);
    chk("vsw_pre_v_err", v_err, 0);
    err_clr = 1'b1;
    pixel();
    chk("vsw_v_err_set_wins", v_err, 1);
    chk("vsw_locked", locked, 0);
    chk("vsw_h_err", h_err, 0);
    vs_w = V_S;
    err_clr = 1'b1;
    pixel();
    chk("err_clr_v_err", v_err, 0);
    run_to(0, 0);
    chk("vsw_relock_vs1", locked, 0);
    run_to(0, 0);
    chk("vsw_relock_vs2", locked, 1);
    chk("vsw_relock_frame_cnt", frame_cnt, 0);
    run_to(0, 0);
    chk("next_frame_cnt", frame_cnt, st(1));
    chk("next_frame_locked", locked, 1);

`ifdef VGA_RX_STATS_EN
    ce_div = 1;
    for (int i = 0; i < 254; i++) run_to(0, 0);
    chk("frame_cnt_255", frame_cnt, 255);
    run_to(0, 0);
    chk("frame_cnt_wrap", frame_cnt, 0);
    chk("wrap_locked", locked, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
